// File: rtl/pipeline_id_stage.sv
// pipeline_id_stage: RV32I instruction-decode stage.
// Classifies the instruction word into its encoding format and picks the ALU
// operation for EX. Both results are registered, so EX sees them one cycle
// after IF presents the instruction.

module pipeline_id_stage (
   input  logic        clk,
   input  logic        rst,            // asynchronous, active-low
   input  logic [31:0] inst,
   output logic [2:0]  decoded_type,
   output logic [3:0]  alu_opcode
);

   localparam int ALU_OPCODE_WIDTH = 4;

   // Instruction format codes as seen by EX.
   typedef enum logic [2:0] {
      FMT_R       = 3'd0,
      FMT_I       = 3'd1,
      FMT_S       = 3'd2,
      FMT_B       = 3'd3,
      FMT_U       = 3'd4,
      FMT_J       = 3'd5,
      FMT_INVALID = 3'd7
   } fmt_e;

   // ALU operation codes as seen by EX.
   typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10,
      ALU_NOP    = 4'd15
   } alu_e;

   // Major opcodes handled by this stage.
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Instruction fields.
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       imm_arith;   // inst[30]: arithmetic-shift select for srai

   assign opcode    = inst[6:0];
   assign funct3    = inst[14:12];
   assign funct7    = inst[31:25];
   assign imm_arith = inst[30];

   // Register and immediate fields are consumed by later stages, not here.
   logic unused_fields;
   assign unused_fields = ^{inst[24:15], inst[11:7]};

   // Base funct3 -> ALU mapping shared by OP (funct7=0) and OP-IMM.
   function automatic alu_e base_alu(input logic [2:0] f3);
      alu_e op;
      unique case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Branch funct3 -> comparison the ALU must perform; NOP marks reserved encodings.
   function automatic alu_e branch_alu(input logic [2:0] f3);
      alu_e op;
      unique case (f3)
         3'b000, 3'b001: op = ALU_SUB;   // beq / bne
         3'b100, 3'b101: op = ALU_SLT;   // blt / bge
         3'b110, 3'b111: op = ALU_SLTU;  // bltu / bgeu
         default:        op = ALU_NOP;   // 010 / 011 are reserved
      endcase
      return op;
   endfunction

   fmt_e type_d, type_q;
   alu_e alu_d,  alu_q;

   // Combinational decode of the current instruction word.
   always_comb begin
      // NOTE: defaulting every output at the top of a combinational block means
      // no path leaves a variable unassigned, so no latch can be inferred.
      type_d = FMT_INVALID;
      alu_d  = ALU_NOP;

      unique case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               type_d = FMT_R;
               alu_d  = base_alu(funct3);
            end else if (funct7 == F7_ALT) begin
               if (funct3 == 3'b000) begin
                  type_d = FMT_R;
                  alu_d  = ALU_SUB;
               end else if (funct3 == 3'b101) begin
                  type_d = FMT_R;
                  alu_d  = ALU_SRA;
               end
            end
         end

         OPC_OP_IMM: begin
            type_d = FMT_I;
            // There is no subi, so funct3 000 is always ADD regardless of inst[30].
            if (funct3 == 3'b101 && imm_arith) begin
               alu_d = ALU_SRA;
            end else begin
               alu_d = base_alu(funct3);
            end
         end

         OPC_LOAD, OPC_JALR: begin
            type_d = FMT_I;
            alu_d  = ALU_ADD;            // base + offset address
         end

         OPC_STORE: begin
            type_d = FMT_S;
            alu_d  = ALU_ADD;            // base + offset address
         end

         OPC_BRANCH: begin
            alu_d = branch_alu(funct3);
            if (alu_d != ALU_NOP) begin
               type_d = FMT_B;
            end
         end

         OPC_LUI: begin
            type_d = FMT_U;
            alu_d  = ALU_PASS_B;         // result is the immediate itself
         end

         OPC_AUIPC: begin
            type_d = FMT_U;
            alu_d  = ALU_ADD;            // pc + immediate
         end

         OPC_JAL: begin
            type_d = FMT_J;
            alu_d  = ALU_ADD;            // link address / target arithmetic
         end

         default: begin
            type_d = FMT_INVALID;
            alu_d  = ALU_NOP;
         end
      endcase
   end

   // Output register: loads the decode on every edge, forced to INVALID/NOP in reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // its pre-edge value; the reset branch makes the outputs safe asynchronously.
      if (!rst) begin
         type_q <= FMT_INVALID;
         alu_q  <= ALU_NOP;
      end else begin
         type_q <= type_d;
         alu_q  <= alu_d;
      end
   end

   assign decoded_type = type_q;
   assign alu_opcode   = alu_q;

endmodule

// File: tb/tb_pipeline_id_stage.sv
// Self-checking bench for pipeline_id_stage: directed vector table, reset
// corner sequences and randomized instructions against a table-based model.

module tb_pipeline_id_stage;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic [2:0]  decoded_type;
   logic [3:0]  alu_opcode;

   int n_checks = 0;
   int n_pass   = 0;

   pipeline_id_stage dut (
      .clk          (clk),
      .rst          (rst),
      .inst         (inst),
      .decoded_type (decoded_type),
      .alu_opcode   (alu_opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic [2:0]  exp_type;
      logic [3:0]  exp_op;
   } vec_t;

   vec_t vecs[11];

   // Compare packed {type, op} against the expected pair.
   task automatic check(input string name, input logic [2:0] exp_type, input logic [3:0] exp_op);
      n_checks++;
      if (decoded_type === exp_type && alu_opcode === exp_op) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got type=%0d op=%0d, expected type=%0d op=%0d",
                  name, decoded_type, alu_opcode, exp_type, exp_op);
      end
   endtask

   // Reference decode computed from lookup tables of the instruction set rules.
   function automatic logic [6:0] ref_decode(input logic [31:0] w);
      int op_tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};      // ADD SLL SLT SLTU XOR SRL OR AND
      int br_tbl[8] = '{1, 1, 15, 15, 3, 3, 4, 4};    // SUB SUB - - SLT SLT SLTU SLTU
      logic [6:0] opc = w[6:0];
      int         f3  = int'(w[14:12]);
      logic [6:0] f7  = w[31:25];
      int         t   = 7;
      int         a   = 15;
      case (opc)
         7'b0110011: begin
            if (f7 == 7'h00) begin
               t = 0; a = op_tbl[f3];
            end else if (f7 == 7'h20 && f3 == 0) begin
               t = 0; a = 1;
            end else if (f7 == 7'h20 && f3 == 5) begin
               t = 0; a = 7;
            end
         end
         7'b0010011: begin
            t = 1;
            a = (f3 == 5 && w[30]) ? 7 : op_tbl[f3];
         end
         7'b0000011, 7'b1100111: begin t = 1; a = 0; end
         7'b0100011:             begin t = 2; a = 0; end
         7'b1100011:             begin if (br_tbl[f3] != 15) begin t = 3; a = br_tbl[f3]; end end
         7'b0110111:             begin t = 4; a = 10; end
         7'b0010111:             begin t = 4; a = 0; end
         7'b1101111:             begin t = 5; a = 0; end
         default:                begin t = 7; a = 15; end
      endcase
      return {3'(t), 4'(a)};
   endfunction

   // Drive one instruction at the falling edge and check it one rising edge later.
   task automatic apply(input string name, input logic [31:0] w,
                        input logic [2:0] exp_type, input logic [3:0] exp_op);
      @(negedge clk);
      inst = w;
      @(posedge clk);
      #2;
      check(name, exp_type, exp_op);
   endtask

   logic [6:0]  valid_opc[11];
   logic [2:0]  prev_type;
   logic [3:0]  prev_op;
   logic [6:0]  exp;
   logic [31:0] w;

   initial begin
      vecs[0]  = '{"add",        32'h00B50533, 3'd0, 4'd0};
      vecs[1]  = '{"sub",        32'h40B50533, 3'd0, 4'd1};
      vecs[2]  = '{"sra",        32'h40B55533, 3'd0, 4'd7};
      vecs[3]  = '{"r_bad_f7",   32'h02B50533, 3'd7, 4'd15};
      vecs[4]  = '{"addi",       32'h00150513, 3'd1, 4'd0};
      vecs[5]  = '{"srai",       32'h40155513, 3'd1, 4'd7};
      vecs[6]  = '{"sw",         32'h00B52023, 3'd2, 4'd0};
      vecs[7]  = '{"blt",        32'h00B54463, 3'd3, 4'd3};
      vecs[8]  = '{"lui",        32'h12345537, 3'd4, 4'd10};
      vecs[9]  = '{"jal",        32'h0080006F, 3'd5, 4'd0};
      vecs[10] = '{"zero",       32'h00000000, 3'd7, 4'd15};

      valid_opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111,
                    7'b1110011};

      // Reset: start high so the drop to 0 is a real falling edge.
      rst  = 1'b1;
      inst = $urandom;
      #1 rst = 1'b0;
      #1 check("reset_async", 3'd7, 4'd15);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         inst = $urandom;
         @(posedge clk);
         #2 check("reset_hold", 3'd7, 4'd15);
      end

      // Directed table, back-to-back: release reset with the first word present.
      prev_type = 3'd7;
      prev_op   = 4'd15;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i == 0) rst = 1'b1;
         inst = vecs[i].inst;
         #1 check({vecs[i].name, "_hold_prev"}, prev_type, prev_op);
         @(posedge clk);
         #2 check(vecs[i].name, vecs[i].exp_type, vecs[i].exp_op);
         prev_type = vecs[i].exp_type;
         prev_op   = vecs[i].exp_op;
      end

      // Mid-stream reset between edges forces reset values without a clock.
      apply("pre_rst_lui", 32'h12345537, 3'd4, 4'd10);
      rst = 1'b0;
      #1 check("midrst_async", 3'd7, 4'd15);
      @(posedge clk);
      #2 check("midrst_held", 3'd7, 4'd15);
      @(negedge clk);
      inst = 32'h0080006F;
      rst  = 1'b1;
      @(posedge clk);
      #2 check("post_rst_jal", 3'd5, 4'd0);

      // Inst changing between edges must not disturb the registered outputs.
      @(negedge clk);
      inst = 32'h00000000;
      #1 inst = 32'h40B50533;
      #1 check("between_edges", 3'd5, 4'd0);
      @(posedge clk);
      #2 check("between_edges_load", 3'd0, 4'd1);

      // Randomized instructions against the reference model.
      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         if ($urandom_range(0, 9) != 0) w[6:0] = valid_opc[$urandom_range(0, 10)];
         case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
         endcase
         exp = ref_decode(w);
         apply("random", w, exp[6:4], exp[3:0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
